// File: rtl/adc_ltc2315_emulator.sv
// LTC2315-12 SPI responder with a built-in 12-bit test-pattern generator.
// Optional macro ADC_EMU_DITHER_EN adds a +/-1 LSB dither to cur_sample.
module adc_ltc2315_emulator #(
    parameter int          FRAME_BITS  = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] LFSR_SEED   = 12'hACE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck,
    input  logic        cs,
    output logic        sdo,
    output logic        sdo_oe,
    input  logic [1:0]  pattern_sel,
    input  logic [11:0] const_data,
    input  logic [11:0] step,
    output logic [11:0] cur_sample,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [CW-1:0] CNT_DATA = CW'(13);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FRAME_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_TAIL  = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sck_q;
    logic                   cs_q;
    logic                   sck_s;
    logic                   cs_s;
    logic                   sck_fall;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [1:0]    state;
    logic [15:0]   shreg;
    logic [CW-1:0] cnt;

    logic [11:0] gen;
    logic [11:0] gen_nxt;
    logic        dir_down;
    logic        dir_nxt;
    logic [11:0] lfsr;
    logic [11:0] lfsr_nxt;
    logic [12:0] sum;
    logic [12:0] diff;
    logic [11:0] sample_nxt;

    // cs resets low so a cs held low through reset is not seen as a new frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '1;
            cs_sync  <= '0;
            sck_q    <= 1'b1;
            cs_q     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_q    <= sck_s;
            cs_q     <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_fall = sck_q & ~sck_s;
    assign cs_fall  = cs_q & ~cs_s;
    assign cs_rise  = ~cs_q & cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sdo        <= 1'b0;
            sdo_oe     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_rise) begin
                state  <= ST_IDLE;
                sdo    <= 1'b0;
                sdo_oe <= 1'b0;
                if (state != ST_IDLE) begin
                    if (cnt >= CNT_DATA) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else if (cs_fall && state == ST_IDLE) begin
                state  <= ST_SHIFT;
                shreg  <= {1'b0, cur_sample, 3'b000};
                cnt    <= '0;
                sdo    <= 1'b0;
                sdo_oe <= 1'b1;
            end else if (sck_fall) begin
                unique case (state)
                    ST_SHIFT: begin
                        shreg <= {shreg[14:0], 1'b0};
                        sdo   <= shreg[14];
                        cnt   <= cnt + 1'b1;
                        if (cnt + 1'b1 == CNT_DATA)
                            state <= ST_TAIL;
                    end
                    ST_TAIL: begin
                        sdo <= 1'b0;
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sum  = {1'b0, gen} + {1'b0, step};
    assign diff = {1'b0, gen} - {1'b0, step};

    always_comb begin
        gen_nxt  = gen;
        dir_nxt  = dir_down;
        lfsr_nxt = lfsr;
        unique case (pattern_sel)
            2'd0: gen_nxt = const_data;
            2'd1: gen_nxt = sum[11:0];
            2'd2: begin
                lfsr_nxt = {lfsr[10:0],
                            lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
                gen_nxt  = lfsr_nxt;
            end
            2'd3: begin
                if (!dir_down) begin
                    if (sum >= 13'h0FFF) begin
                        gen_nxt = 12'hFFF;
                        dir_nxt = 1'b1;
                    end else begin
                        gen_nxt = sum[11:0];
                    end
                end else begin
                    if (diff[12] || diff == 13'd0) begin
                        gen_nxt = 12'h000;
                        dir_nxt = 1'b0;
                    end else begin
                        gen_nxt = diff[11:0];
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef ADC_EMU_DITHER_EN
    logic [7:0] dlfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dlfsr <= 8'h5B;
        else if (cs_rise)
            dlfsr <= {dlfsr[6:0], dlfsr[7] ^ dlfsr[5] ^ dlfsr[4] ^ dlfsr[3]};
    end

    // LSB pair 00 -> -1, 11 -> +1, otherwise no offset
    always_comb begin
        sample_nxt = gen_nxt;
        unique case (dlfsr[1:0])
            2'b00:   if (gen_nxt != 12'h000) sample_nxt = gen_nxt - 12'd1;
            2'b11:   if (gen_nxt != 12'hFFF) sample_nxt = gen_nxt + 12'd1;
            default: ;
        endcase
    end
`else
    assign sample_nxt = gen_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen        <= '0;
            dir_down   <= 1'b0;
            lfsr       <= LFSR_SEED;
            cur_sample <= '0;
        end else if (cs_rise) begin
            gen        <= gen_nxt;
            dir_down   <= dir_nxt;
            lfsr       <= lfsr_nxt;
            cur_sample <= sample_nxt;
        end
    end

endmodule

// File: tb/tb_adc_ltc2315_emulator.sv
// Scoreboard bench for adc_ltc2315_emulator: drives SPI frames, decodes sdo.
// Expected words are queued at frame start from a spec-level generator model.
module tb_adc_ltc2315_emulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b1;
    logic        cs = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [11:0] const_data = 12'h000;
    logic [11:0] step = 12'h000;
    logic        sdo;
    logic        sdo_oe;
    logic [11:0] cur_sample;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    adc_ltc2315_emulator dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs),
        .sdo(sdo), .sdo_oe(sdo_oe),
        .pattern_sel(pattern_sel), .const_data(const_data), .step(step),
        .cur_sample(cur_sample), .frame_done(frame_done),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    logic [11:0] m_gen;
    logic [11:0] m_lfsr;
    logic [11:0] m_cur;
    bit          m_dir;
    logic [15:0] m_cnt;
    logic [15:0] exp_q[$];

    logic [11:0] saw_tbl[4] = '{12'h000, 12'h800, 12'h000, 12'h800};
    logic [11:0] tri_tbl[6] = '{12'h7FF, 12'hFFE, 12'hFFF, 12'h800, 12'h001, 12'h000};
    logic [11:0] lfsr_tbl[2] = '{12'h59D, 12'hB3A};

    function automatic bit sample_ok(logic [11:0] got, logic [11:0] exp);
`ifdef ADC_EMU_DITHER_EN
        int d;
        d = int'(got) - int'(exp);
        return (^got !== 1'bx) && d >= -1 && d <= 1;
`else
        return got === exp;
`endif
    endfunction

    function automatic bit word_ok(logic [15:0] got, logic [15:0] exp);
        return got[15] === 1'b0 && got[2:0] === 3'b000 &&
               sample_ok(got[14:3], exp[14:3]);
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_gen  = 12'h000;
        m_dir  = 1'b0;
        m_lfsr = 12'hACE;
        m_cur  = 12'h000;
        m_cnt  = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_rise();
        int t;
        case (pattern_sel)
            2'd0: m_gen = const_data;
            2'd1: m_gen = 12'((int'(m_gen) + int'(step)) % 4096);
            2'd2: begin
                m_lfsr = {m_lfsr[10:0],
                          m_lfsr[11] ^ m_lfsr[10] ^ m_lfsr[9] ^ m_lfsr[3]};
                m_gen = m_lfsr;
            end
            default: begin
                if (!m_dir) begin
                    t = int'(m_gen) + int'(step);
                    if (t >= 4095) begin
                        m_gen = 12'hFFF;
                        m_dir = 1'b1;
                    end else begin
                        m_gen = 12'(t);
                    end
                end else begin
                    t = int'(m_gen) - int'(step);
                    if (t <= 0) begin
                        m_gen = 12'h000;
                        m_dir = 1'b0;
                    end else begin
                        m_gen = 12'(t);
                    end
                end
            end
        endcase
        m_cur = m_gen;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        exp_q.push_back({1'b0, m_cur, 3'b000});
        clks(8);
    endtask

    task automatic do_falls(input int n, output logic [15:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            if (i < 16) w[15-i] = sdo;
            sck = 1'b0;
            clks(4);
            sck = 1'b1;
            clks(4);
        end
    endtask

    task automatic frame_end(input bit exp_done, input bit exp_err,
                             input string nm);
        int nd;
        int ne;
        nd = 0;
        ne = 0;
        cs = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nd += int'(frame_done);
            ne += int'(frame_err);
        end
        if (exp_done) m_cnt = m_cnt + 16'd1;
        model_rise();
        n_tests++;
        if (nd !== int'(exp_done) || ne !== int'(exp_err)) begin
            n_fail++;
            $display("FAIL %s pulses: done=%0d err=%0d, want done=%0d err=%0d",
                     nm, nd, ne, exp_done, exp_err);
        end
        n_tests++;
        if (frame_cnt !== m_cnt || sdo_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s end: frame_cnt=%h sdo_oe=%b, want %h 0",
                     nm, frame_cnt, sdo_oe, m_cnt);
        end
        n_tests++;
        if (!sample_ok(cur_sample, m_cur)) begin
            n_fail++;
            $display("FAIL %s cur_sample=%h want %h", nm, cur_sample, m_cur);
        end
    endtask

    task automatic check_word(input logic [15:0] w, input string nm);
        logic [15:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard empty, got %h", nm, w);
        end else begin
            e = exp_q.pop_front();
            if (!word_ok(w, e)) begin
                n_fail++;
                $display("FAIL %s word=%h want %h", nm, w, e);
            end
        end
    endtask

    task automatic full_frame(input string nm, output logic [15:0] w);
        frame_start();
        do_falls(16, w);
        frame_end(1'b1, 1'b0, nm);
        check_word(w, nm);
    endtask

    task automatic do_reset();
        pattern_sel = 2'd0;
        const_data  = 12'h000;
        step        = 12'h000;
        cs          = 1'b0;
        sck         = 1'b1;
        rst_n       = 1'b0;
        clks(3);
        rst_n = 1'b1;
        clks(4);
        model_reset();
        frame_end(1'b0, 1'b0, "reset_rise");
    endtask

    task automatic test_reset();
        pattern_sel = 2'd0;
        const_data  = 12'h000;
        cs          = 1'b0;
        rst_n       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sck = 1'b0;
            clks(2);
            sck = 1'b1;
            clks(2);
        end
        n_tests++;
        if (sdo !== 1'b0 || sdo_oe !== 1'b0 || frame_cnt !== 16'h0 ||
            cur_sample !== 12'h0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs sdo=%b oe=%b cnt=%h cur=%h done=%b err=%b",
                     sdo, sdo_oe, frame_cnt, cur_sample, frame_done, frame_err);
        end
        rst_n = 1'b1;
        clks(4);
        model_reset();
        frame_end(1'b0, 1'b0, "reset_first_rise");
    endtask

    task automatic test_constant();
        logic [15:0] w;
        do_reset();
        const_data = 12'hA5C;
        frame_start();
        n_tests++;
        if (sdo_oe !== 1'b1 || sdo !== 1'b0) begin
            n_fail++;
            $display("FAIL const_start oe=%b sdo=%b want 1 0", sdo_oe, sdo);
        end
        do_falls(16, w);
        frame_end(1'b1, 1'b0, "const0");
        check_word(w, "const0");
        n_tests++;
        if (!word_ok(w, 16'h0000)) begin
            n_fail++;
            $display("FAIL const0_abs word=%h want 0000", w);
        end
        full_frame("const1", w);
        n_tests++;
        if (!word_ok(w, 16'h52E0)) begin
            n_fail++;
            $display("FAIL const1_abs word=%h want 52e0", w);
        end
        n_tests++;
        if (frame_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL const_cnt frame_cnt=%0d want 2", frame_cnt);
        end
    endtask

    task automatic test_sawtooth();
        logic [15:0] w;
        do_reset();
        pattern_sel = 2'd1;
        step        = 12'h800;
        for (int i = 0; i < 4; i++) begin
            full_frame("saw", w);
            n_tests++;
            if (!sample_ok(w[14:3], saw_tbl[i])) begin
                n_fail++;
                $display("FAIL saw_abs%0d data=%h want %h", i, w[14:3], saw_tbl[i]);
            end
        end
    endtask

    task automatic test_truncated();
        logic [15:0] w;
        logic [15:0] dummy;
        do_reset();
        pattern_sel = 2'd1;
        step        = 12'h010;
        full_frame("trunc_pre", w);
        frame_start();
        do_falls(8, w);
        frame_end(1'b0, 1'b1, "trunc");
        dummy = exp_q.pop_front();
        full_frame("trunc_post", w);
        n_tests++;
        if (!sample_ok(w[14:3], 12'h020)) begin
            n_fail++;
            $display("FAIL trunc_adv data=%h want 020", w[14:3]);
        end
    endtask

    task automatic test_triangle();
        logic [15:0] w;
        do_reset();
        pattern_sel = 2'd3;
        step        = 12'h7FF;
        for (int i = 0; i < 6; i++) begin
            full_frame("tri", w);
            n_tests++;
            if (!sample_ok(cur_sample, tri_tbl[i])) begin
                n_fail++;
                $display("FAIL tri_abs%0d cur=%h want %h", i, cur_sample, tri_tbl[i]);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [15:0] w;
        do_reset();
        pattern_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            full_frame("lfsr", w);
            if (i < 2) begin
                n_tests++;
                if (!sample_ok(cur_sample, lfsr_tbl[i])) begin
                    n_fail++;
                    $display("FAIL lfsr_abs%0d cur=%h want %h", i, cur_sample, lfsr_tbl[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] w;
        int nd;
        int ne;
        do_reset();
        const_data = 12'hFFF;
        full_frame("sim_pre", w);
        frame_start();
        do_falls(15, w);
        w[0] = sdo;
        nd = 0;
        ne = 0;
        sck = 1'b0;
        cs  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nd += int'(frame_done);
            ne += int'(frame_err);
        end
        sck = 1'b1;
        clks(4);
        m_cnt = m_cnt + 16'd1;
        model_rise();
        n_tests++;
        if (nd != 1 || ne != 0 || sdo_oe !== 1'b0 || sdo !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_edge done=%0d err=%0d oe=%b sdo=%b want 1 0 0 0",
                     nd, ne, sdo_oe, sdo);
        end
        n_tests++;
        if (frame_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL sim_cnt frame_cnt=%h want %h", frame_cnt, m_cnt);
        end
        check_word(w, "sim_word");
        full_frame("sim_post", w);
        n_tests++;
        if (!sample_ok(w[14:3], 12'hFFF)) begin
            n_fail++;
            $display("FAIL sim_post_abs data=%h want fff", w[14:3]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] w;
        do_reset();
        pattern_sel = 2'd1;
        step        = 12'h100;
        full_frame("mid_pre", w);
        frame_start();
        do_falls(5, w);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (sdo_oe !== 1'b0 || sdo !== 1'b0 || frame_cnt !== 16'h0 ||
            cur_sample !== 12'h0) begin
            n_fail++;
            $display("FAIL mid_reset oe=%b sdo=%b cnt=%h cur=%h want 0 0 0 0",
                     sdo_oe, sdo, frame_cnt, cur_sample);
        end
        clks(2);
        rst_n = 1'b1;
        clks(4);
        model_reset();
        frame_end(1'b0, 1'b0, "mid_rise");
        full_frame("mid_post", w);
        n_tests++;
        if (!sample_ok(w[14:3], 12'h100)) begin
            n_fail++;
            $display("FAIL mid_post_abs data=%h want 100", w[14:3]);
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_sawtooth();
        test_truncated();
        test_triangle();
        test_lfsr();
        test_simultaneous();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_ltc2315_emulator.md
Name: adc_ltc2315_emulator

Overview:
- Synthesizable SPI responder that emulates one LTC2315-12 ADC toward the adc_ltc2315 capture master.
- Drives sdo from the master's sck/cs using an internal 12-bit test-pattern generator.
- Used on the board (in place of a real ADC, via loopback pins) and in simulation to verify the capture path, FIFO and Ethernet chain with known data.
- Oversamples sck/cs on its own clock, so sck must be ≤ clk/4.

Parameters:
- FRAME_BITS, 16, sck falling edges per frame the master issues; must be ≥ 14.
- SYNC_STAGES, 2, synchronizer depth on sck and cs (2..3).
- LFSR_SEED, 12'hACE, reset seed of the pattern LFSR; must be non-zero.

Ports:
- clk  in  1  oversampling clock, e.g. clk_2x 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- sck  in  1  SPI clock from master; idles high.
- cs  in  1  chip select from master, active low; rising edge = conversion start.
- sdo  out  1  serial data, MSB first.
- sdo_oe  out  1  1 while the frame is active (cs synchronized low); for IOBUF/tri-state.
- pattern_sel  in  2  0 = constant, 1 = sawtooth, 2 = LFSR, 3 = triangle.
- const_data  in  12  value used in constant mode.
- step  in  12  increment for sawtooth/triangle.
- cur_sample  out  12  sample loaded into the current or next frame.
- frame_done  out  1  one-cycle pulse on a complete frame.
- frame_err  out  1  one-cycle pulse on a truncated frame.
- frame_cnt  out  16  complete frames since reset; wraps at 16'hFFFF → 0.

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous, active-low. All state is reset asynchronously. No other clock domain.

Reset values:
- sdo = 0, sdo_oe = 0, frame_done = 0, frame_err = 0, frame_cnt = 0, cur_sample = 0.
- LFSR = LFSR_SEED; triangle direction = up; FSM = IDLE.

Input synchronization:
- sck and cs pass through SYNC_STAGES flops, then one edge register.
- Edges are detected only on the synchronized signals.
- Latency from a pin edge to the sdo change is SYNC_STAGES+1 clk cycles (3 by default).

FSM states: IDLE, SHIFT, TAIL.
- IDLE → SHIFT on cs falling edge:
  - load shreg[15:0] = {1'b0, cur_sample, 3'b000};
  - sdo = 0 (leading zero), sdo_oe = 1, bit counter = 0.
- SHIFT, on each sck falling edge:
  - shreg <<= 1, sdo = new shreg[15], counter += 1;
  - when counter reaches 13 (all 12 data bits presented), go to TAIL.
- TAIL: sdo = 0 for the remaining edges up to FRAME_BITS. Edges beyond FRAME_BITS are ignored and sdo stays 0.
- SHIFT or TAIL on cs rising edge:
  - sdo_oe = 0, sdo = 0, FSM → IDLE;
  - if the counter was ≥ 13: frame_done pulse, frame_cnt += 1;
  - otherwise: frame_err pulse, frame_cnt unchanged;
  - in both cases the generator advances once (a conversion is started).
- sck rising edges are ignored; sck edges while in IDLE are ignored.
- Simultaneous sck fall and cs rise in the same synchronized cycle: cs wins and the shift is discarded.
- cs rising edge while in IDLE (e.g. after reset with cs low): generator advances; no pulse.

Generator (updates cur_sample only on cs rise, so frame N carries the value computed at the end of frame N−1):
- Constant: cur_sample = const_data.
- Sawtooth: cur_sample = (cur_sample + step) mod 4096.
- LFSR: 12-bit Fibonacci with taps 12, 11, 10, 4; cur_sample = LFSR state.
- Triangle:
  - up: add step, saturate at 4095, then switch to down;
  - down: subtract step, saturate at 0, then switch to up.
- A pattern_sel change takes effect at the next cs rise.

Reset mid-frame: outputs return to reset values immediately. A frame already in progress is not resumed; the next valid cs fall starts cleanly.

Optional Feature:
- Macro: ADC_EMU_DITHER_EN.
- When defined: a separate 8-bit LFSR (seed 8'h5B) is sampled at each cs rise. Its 2 LSBs map to an offset of −1, 0, 0, +1 LSB, added to the generator output before cur_sample is loaded, saturating at 0 and 4095. The generator state itself is not dithered.
- When undefined: no dither logic is present; cur_sample equals the generator output exactly.

Test Plan:
- Reset: hold rst_n=0 with cs=0 and toggling sck → sdo=0, sdo_oe=0, frame_cnt=0. Release; first cs rise → no frame_done or frame_err.
- Constant mode, const_data=12'hA5C:
  - first frame (16 sck falls) reads 16'h0000, since cur_sample was still 0;
  - second frame reads sdo sequence 0,1010_0101_1100,000 = 16'h52E0;
  - frame_done pulses once per frame; frame_cnt=2.
- Sawtooth mode, step=12'h800, four frames → decoded data 0x000, 0x800, 0x000, 0x800 (wrap).
- Truncated frame: cs rises after 8 sck falls → frame_err=1 for one cycle, frame_cnt unchanged; the next full frame shows the generator advanced by exactly 2 steps.
- Triangle mode, step=12'h7FF, from 0 → samples 0x7FF, 0xFFE, 0xFFF (saturated), 0x800, 0x001, 0x000.
- Simultaneous event: sck fall and cs rise within the same clk cycle → no extra shift, sdo_oe falls; with ADC_EMU_DITHER_EN in constant mode const_data=12'hFFF → samples never exceed 0xFFF.
